bcd_stopwatch_ctrl: RTL

Stopwatch controller that sequences a chain of one-digit BCD counters. Contains a run/pause/clear state machine, a prescaler that turns the system clock into count ticks, and ripple-free synchronous carry generation across `DIGITS` decade stages. It sits between the push-button pulse logic and the display path, and presents a packed BCD count to the display path.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_stopwatch_ctrl_if.sv | 22 ++
 rtl/bcd_digit.sv | 28 ++
 rtl/bcd_stopwatch_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD stopwatch: controller state encoding and digit limits.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StOvf
  } sw_state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control pulses in, packed BCD display and status out, between button logic and the stopwatch.
interface bcd_stopwatch_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start_stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   disp;
  logic                  running;
  logic                  overflow;
  logic                  lap_active;

  modport master (
    output start_stop, clear, lap,
    input  disp, running, overflow, lap_active
  );

  modport slave (
    input  start_stop, clear, lap,
    output disp, running, overflow, lap_active
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade stage: increments on en with 9->0 wrap, synchronous clear has priority.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       at_max
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= BCD_ZERO;
    end else if (clr) begin
      cnt_q <= BCD_ZERO;
    end else if (en) begin
      cnt_q <= (cnt_q == BCD_MAX) ? BCD_ZERO : cnt_q + 4'd1;
    end
  end

  assign q      = cnt_q;
  assign at_max = (cnt_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM, tick prescaler and carry chain over DIGITS stages.
// Optional lap display freeze is built when BCD_SW_LAP_HOLD_EN is defined.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned     PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  sw_state_e           state_q;
  logic [PreW-1:0]     pre_q;
  logic                running_q;
  logic                overflow_q;
  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   en;
  logic [4*DIGITS-1:0] live;
  logic                tick;
  logic                all_max;

  assign all_max = &at_max;
  // The edge that pauses or clears is already treated as not running.
  assign tick    = (state_q == StRun) && (pre_q == PreMax) && !bus.start_stop && !bus.clear;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGITS-1:0] LowMask = DIGITS'((1 << i) - 1);

    // Enable when every lower digit is at 9; saturation withholds all enables.
    assign en[i] = tick & ~all_max & (&(at_max | ~LowMask));

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .clr    (bus.clear),
      .q      (live[4*i +: 4]),
      .at_max (at_max[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_stop) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (bus.start_stop) begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end else if (tick) begin
            pre_q <= '0;
            if (all_max) begin
              state_q    <= StOvf;
              running_q  <= 1'b0;
              overflow_q <= 1'b1;
            end
          end else begin
            pre_q <= pre_q + PreW'(1);
          end
        end
        StPause: begin
          if (bus.start_stop) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StOvf: begin
        end
        default: begin
          state_q    <= StIdle;
          running_q  <= 1'b0;
          overflow_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.running  = running_q;
  assign bus.overflow = overflow_q;

`ifdef BCD_SW_LAP_HOLD_EN
  logic                lap_q;
  logic [4*DIGITS-1:0] hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else if (bus.clear) begin
      lap_q <= 1'b0;
    end else if (bus.lap && (state_q == StRun || state_q == StPause)) begin
      lap_q <= !lap_q;
      if (!lap_q) begin
        hold_q <= live;
      end
    end
  end

  assign bus.lap_active = lap_q;
  assign bus.disp       = lap_q ? hold_q : live;
`else
  logic unused_lap;

  assign unused_lap     = bus.lap;
  assign bus.lap_active = 1'b0;
  assign bus.disp       = live;
`endif

endmodule
